// File: rtl/seq_booth_multiplier_if.sv
// Start/done handshake and operand/product bus for seq_booth_multiplier.
// The controller drives the master side; the multiplier is the slave.
interface seq_booth_multiplier_if #(
   parameter int unsigned WIDTH = 8
);
   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start,
      output multiplicand,
      output multiplier,
      input  busy,
      input  done,
      input  product
   );

   modport slave (
      input  start,
      input  multiplicand,
      input  multiplier,
      output busy,
      output done,
      output product
   );
endinterface

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth signed multiplier, one partial product per clock.
// Define SEQ_MULT_OUT_REG_EN to add an output register stage (latency WIDTH+1).
module seq_booth_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input logic               clk,
   input logic               reset_n,
   seq_booth_multiplier_if.slave bus
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StOut,
      StDone
   } state_e;

   state_e               state_q, state_d;
   logic [WIDTH:0]       acc_q, acc_d;
   logic [WIDTH:0]       m_q, m_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic                 q1_q, q1_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       acc_sh;
   logic [WIDTH-1:0]     q_sh;
   logic [2*WIDTH-1:0]   result;

`ifdef SEQ_MULT_OUT_REG_EN
   logic [2*WIDTH-1:0]   stage_q, stage_d;
`endif

   // One Booth step: add/sub in WIDTH+1 bits, then arithmetic shift of {acc,q,q_1}.
   always_comb begin
      unique case ({q_q[0], q1_q})
         2'b01:   sum = acc_q + m_q;
         2'b10:   sum = acc_q - m_q;
         default: sum = acc_q;
      endcase
      acc_sh = {sum[WIDTH], sum[WIDTH:1]};
      q_sh   = {sum[0], q_q[WIDTH-1:1]};
      result = {acc_sh[WIDTH-1:0], q_sh};
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      m_d       = m_q;
      q_d       = q_q;
      q1_d      = q1_q;
      count_d   = count_q;
      product_d = product_q;
`ifdef SEQ_MULT_OUT_REG_EN
      stage_d   = stage_q;
`endif

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               acc_d   = '0;
               m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
               q_d     = bus.multiplier;
               q1_d    = 1'b0;
               count_d = '0;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            acc_d   = acc_sh;
            q_d     = q_sh;
            q1_d    = q_q[0];
            count_d = count_q + CntW'(1);
            if (count_q == LastCnt) begin
`ifdef SEQ_MULT_OUT_REG_EN
               stage_d   = result;
               state_d   = StOut;
`else
               product_d = result;
               state_d   = StDone;
`endif
            end
         end
`ifdef SEQ_MULT_OUT_REG_EN
         StOut: begin
            product_d = stage_q;
            state_d   = StDone;
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         m_q       <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         m_q       <= m_d;
         q_q       <= q_d;
         q1_q      <= q1_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

`ifdef SEQ_MULT_OUT_REG_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end
`endif

   assign bus.busy    = (state_q == StRun) || (state_q == StOut);
   assign bus.done    = (state_q == StDone);
   assign bus.product = product_q;

   a_done_one_cycle : assert property (@(posedge clk) disable iff (!reset_n)
      bus.done |=> !bus.done);
   a_busy_done_excl : assert property (@(posedge clk) disable iff (!reset_n)
      !(bus.busy && bus.done));

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed and table-driven checks for seq_booth_multiplier at WIDTH=8.
module tb_seq_booth_multiplier;
   localparam int W = 8;
`ifdef SEQ_MULT_OUT_REG_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   seq_booth_multiplier_if #(.WIDTH(W)) bus ();

   seq_booth_multiplier #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [7:0]  m;
      logic [7:0]  q;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[12];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Accept one operation, scramble operands, then time done and check product.
   task automatic run_op(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp,
                         input string name);
      int   seen;
      logic busy_ok;
      seen    = 0;
      busy_ok = 1'b1;
      @(negedge clk);
      bus.start        = 1'b1;
      bus.multiplicand = m;
      bus.multiplier   = q;
      @(posedge clk);
      #1;
      @(negedge clk);
      bus.start        = 1'b0;
      bus.multiplicand = ~m;
      bus.multiplier   = q + 8'd1;
      for (int k = 1; k <= LAT + 4; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            seen = k;
            break;
         end
         if (!bus.busy) busy_ok = 1'b0;
      end
      check({name, " latency"}, seen, LAT);
      check({name, " busy"}, {31'd0, busy_ok}, 32'd1);
      check({name, " product"}, {16'd0, bus.product}, {16'd0, exp});
      @(posedge clk);
      #1;
      check({name, " done width"}, {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      logic [7:0]         m2, q2;
      logic signed [7:0]  rm, rq;
      logic signed [15:0] rp;
      int                 seen;
      logic               bad;

      vecs[0]  = '{8'd7,    8'hFD, 16'hFFEB};
      vecs[1]  = '{8'h80,   8'h80, 16'h4000};
      vecs[2]  = '{8'h80,   8'h7F, 16'hC080};
      vecs[3]  = '{8'h00,   8'hFF, 16'h0000};
      vecs[4]  = '{8'd5,    8'd6,  16'h001E};
      vecs[5]  = '{8'hFF,   8'hFF, 16'h0001};
      vecs[6]  = '{8'h7F,   8'h7F, 16'h3F01};
      vecs[7]  = '{8'h80,   8'h01, 16'hFF80};
      vecs[8]  = '{8'h01,   8'h80, 16'hFF80};
      vecs[9]  = '{8'd100,  8'h9C, 16'hD8F0};
      vecs[10] = '{8'hF9,   8'hF7, 16'h003F};
      vecs[11] = '{8'd13,   8'd11, 16'h008F};

      bus.start        = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      reset_n          = 1'b0;
      #1;
      check("reset busy", {31'd0, bus.busy}, 32'd0);
      check("reset done", {31'd0, bus.done}, 32'd0);
      check("reset product", {16'd0, bus.product}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (vecs[i]) run_op(vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("vec%0d", i));

      // Reset after E3 of a new run: outputs clear at once and no done follows.
      @(negedge clk);
      bus.start        = 1'b1;
      bus.multiplicand = 8'd9;
      bus.multiplier   = 8'd9;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort busy", {31'd0, bus.busy}, 32'd0);
      check("abort done", {31'd0, bus.done}, 32'd0);
      check("abort product", {16'd0, bus.product}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bad = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) bad = 1'b1;
      end
      check("abort no done", {31'd0, bad}, 32'd0);

      // start held high with operands changing every cycle.
      @(negedge clk);
      bus.start        = 1'b1;
      bus.multiplicand = 8'd3;
      bus.multiplier   = 8'd5;
      @(posedge clk);
      seen = 0;
      for (int k = 1; k <= LAT + 4; k++) begin
         @(negedge clk);
         bus.multiplicand = 8'($urandom);
         bus.multiplier   = 8'($urandom);
         @(posedge clk);
         #1;
         if (bus.done) begin
            seen = k;
            break;
         end
      end
      check("b2b first latency", seen, LAT);
      check("b2b first product", {16'd0, bus.product}, 32'h000F);
      @(negedge clk);
      m2 = 8'hE5;
      q2 = 8'h0B;
      bus.multiplicand = m2;
      bus.multiplier   = q2;
      @(posedge clk);
      #1;
      check("b2b second accept busy", {31'd0, bus.busy}, 32'd1);
      check("b2b product held", {16'd0, bus.product}, 32'h000F);
      seen = 0;
      for (int k = 1; k <= LAT + 4; k++) begin
         @(negedge clk);
         bus.multiplicand = 8'($urandom);
         bus.multiplier   = 8'($urandom);
         @(posedge clk);
         #1;
         if (bus.done) begin
            seen = k;
            break;
         end
      end
      // 0xE5 = -27, 0x0B = 11 -> -297 = 0xFED7
      check("b2b second latency", seen, LAT);
      check("b2b second product", {16'd0, bus.product}, 32'h0000FED7);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);

      for (int i = 0; i < 150; i++) begin
         rm = 8'($urandom);
         rq = 8'($urandom);
         rp = rm * rq;
         run_op(rm, rq, rp, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no end expected end of test");
      $fatal(1, "timeout");
   end
endmodule
